// File: rtl/dac_frame_sender_pkg.sv
// Shared types and widths for the DAC frame sender.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package dac_frame_sender_pkg;

    localparam int FRAME_W = 16;
    localparam int DAC_W   = 12;
    localparam int CFG_W   = FRAME_W - DAC_W;

    // Sender FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    // One DAC command word as shifted on the wire, MSB first
    typedef struct packed {
        logic [CFG_W-1:0] cfg;
        logic [DAC_W-1:0] dac;
    } frame_t;

endpackage

// File: rtl/dac_frame_sender.sv
// Converts wave samples into 16-bit DAC frames and feeds them bytewise to an SPI TX master.
// Latency: data_valid_strobe_o 2 cycles after sample_valid_strobe_i when idle with nothing pending.
// Backpressure: one-entry pending buffer; a strobe into a full buffer overwrites it and pulses overrun_o.
//
// Sits directly upstream of the SPI TX master: data_o -> data_i, data_valid_strobe_o -> strobe,
// master tx_ready_o -> tx_ready_i. The master reads data_o live while shifting, so data_o is
// held from SEND until the FSM leaves WAIT_DONE.
module dac_frame_sender
    import dac_frame_sender_pkg::*;
#(
    parameter int         SAMPLE_WIDTH  = 12,
    parameter logic [3:0] CONFIG_NIBBLE = 4'b0011,
    parameter bit         SIGNED_INPUT  = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [SAMPLE_WIDTH-1:0] sample_i,
    input  logic                    sample_valid_strobe_i,
    output logic                    sample_ready_o,
    output logic [7:0]              data_o,
    output logic                    data_valid_strobe_o,
    input  logic                    tx_ready_i,
    output logic                    frame_done_strobe_o,
    output logic                    overrun_o
);

    logic [DAC_W-1:0] aligned;
    logic [DAC_W-1:0] dac_word;
    frame_t           in_frame;
    frame_t           pending_frame;
    logic             pending_valid;
    logic             consume;
    frame_t           frame_q;
    logic             byte_idx;
    state_t           state;

    // Fit the sample into the 12-bit DAC word: keep MSBs, zero-pad narrow samples
    generate
        if (SAMPLE_WIDTH > DAC_W) begin : g_trunc
            logic unused_lsbs;
            assign aligned     = sample_i[SAMPLE_WIDTH-1 -: DAC_W];
            assign unused_lsbs = ^sample_i[SAMPLE_WIDTH-DAC_W-1:0];
        end else if (SAMPLE_WIDTH == DAC_W) begin : g_exact
            assign aligned = sample_i;
        end else begin : g_pad
            assign aligned = {sample_i, {(DAC_W-SAMPLE_WIDTH){1'b0}}};
        end
    endgenerate

    // Two's complement to offset binary is just an MSB flip
    assign dac_word = SIGNED_INPUT ? {~aligned[DAC_W-1], aligned[DAC_W-2:0]} : aligned;
    assign in_frame = '{cfg: CONFIG_NIBBLE, dac: dac_word};

    // The FSM drains the pending entry only when it is idle
    assign consume        = (state == ST_IDLE) && pending_valid;
    assign sample_ready_o = ~pending_valid;

    // Pending buffer: a new strobe always wins; it only counts as overrun if nothing drained it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_valid <= 1'b0;
            pending_frame <= '0;
            overrun_o     <= 1'b0;
        end else begin
            overrun_o <= sample_valid_strobe_i && pending_valid && !consume;
            if (sample_valid_strobe_i) begin
                pending_frame <= in_frame;
                pending_valid <= 1'b1;
            end else if (consume) begin
                pending_valid <= 1'b0;
            end
        end
    end

    // Byte sequencer: hand each byte over, wait for the master to go busy, then for it to finish
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state               <= ST_IDLE;
            frame_q             <= '0;
            byte_idx            <= 1'b0;
            data_o              <= 8'h00;
            data_valid_strobe_o <= 1'b0;
            frame_done_strobe_o <= 1'b0;
        end else begin
            data_valid_strobe_o <= 1'b0;
            frame_done_strobe_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pending_valid) begin
                        frame_q             <= pending_frame;
                        byte_idx            <= 1'b0;
                        data_o              <= pending_frame[15:8];
                        data_valid_strobe_o <= 1'b1;
                        state               <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (!tx_ready_i) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_ready_i) begin
                        if (!byte_idx) begin
                            byte_idx            <= 1'b1;
                            data_o              <= frame_q[7:0];
                            data_valid_strobe_o <= 1'b1;
                            state               <= ST_SEND;
                        end else begin
                            frame_done_strobe_o <= 1'b1;
                            state               <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_frame_sender.sv
// Directed bench for dac_frame_sender with a behavioural SPI mode-0 TX master (2 clocks per half bit).
// Latency: checks the 2-cycle strobe-to-byte latency and full-frame MOSI contents.
// Backpressure: exercises overrun, coincident refill and mid-frame reset.
module tb_dac_frame_sender;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [11:0] sample_i = '0;
    logic        sample_valid_strobe_i = 1'b0;
    logic        tx_ready_i = 1'b1;

    logic        sample_ready_o, data_valid_strobe_o, frame_done_strobe_o, overrun_o;
    logic [7:0]  data_o;
    logic        sample_ready_u, data_valid_u, frame_done_u, overrun_u;
    logic [7:0]  data_o_u;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int ovr_cnt  = 0;
    int stab_err = 0;
    bit chk_stable = 1'b1;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic [7:0] rx_q[$];
    logic [7:0] rx_u_q[$];

    always #5 clk_i = ~clk_i;

    dac_frame_sender dut (
        .clk_i(clk_i), .rst_i(rst_i), .sample_i(sample_i),
        .sample_valid_strobe_i(sample_valid_strobe_i), .sample_ready_o(sample_ready_o),
        .data_o(data_o), .data_valid_strobe_o(data_valid_strobe_o), .tx_ready_i(tx_ready_i),
        .frame_done_strobe_o(frame_done_strobe_o), .overrun_o(overrun_o)
    );

    dac_frame_sender #(.SIGNED_INPUT(1'b0)) dut_u (
        .clk_i(clk_i), .rst_i(rst_i), .sample_i(sample_i),
        .sample_valid_strobe_i(sample_valid_strobe_i), .sample_ready_o(sample_ready_u),
        .data_o(data_o_u), .data_valid_strobe_o(data_valid_u), .tx_ready_i(tx_ready_i),
        .frame_done_strobe_o(frame_done_u), .overrun_o(overrun_u)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pulse counters, sampled mid-cycle
    always @(negedge clk_i) begin
        if (frame_done_strobe_o) done_cnt++;
        if (overrun_o) ovr_cnt++;
    end

    // SPI TX master model: goes busy the cycle after the strobe, shifts data_o live MSB first
    initial begin
        logic [7:0] snap;
        logic [7:0] shreg;
        forever begin
            @(posedge clk_i); #1;
            if (data_valid_strobe_o) begin
                snap = data_o;
                shreg = '0;
                @(posedge clk_i); #1;
                tx_ready_i = 1'b0;
                for (int b = 7; b >= 0; b--) begin
                    mosi = data_o[b];
                    repeat (2) begin
                        @(posedge clk_i); #1;
                        if (chk_stable && data_o !== snap) stab_err++;
                    end
                    sclk = 1'b1;
                    shreg = {shreg[6:0], mosi};
                    repeat (2) begin
                        @(posedge clk_i); #1;
                        if (chk_stable && data_o !== snap) stab_err++;
                    end
                    sclk = 1'b0;
                end
                rx_q.push_back(shreg);
                rx_u_q.push_back(data_o_u);
                tx_ready_i = 1'b1;
            end
        end
    end

    task automatic send(input logic [11:0] s);
        sample_i = s;
        sample_valid_strobe_i = 1'b1;
        @(posedge clk_i); #1;
        sample_valid_strobe_i = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input logic [15:0] exp_s, input logic [15:0] exp_u);
        bit seen;
        logic [7:0] b0, b1;
        seen = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk_i); #1;
            if (frame_done_strobe_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done"}, {31'd0, seen}, 32'd1);
        if (rx_q.size() >= 2 && rx_u_q.size() >= 2) begin
            b0 = rx_q.pop_front();
            b1 = rx_q.pop_front();
            chk({tag, "_mosi"}, {16'd0, b0, b1}, {16'd0, exp_s});
            b0 = rx_u_q.pop_front();
            b1 = rx_u_q.pop_front();
            chk({tag, "_unsigned"}, {16'd0, b0, b1}, {16'd0, exp_u});
        end else begin
            chk({tag, "_nbytes"}, rx_q.size(), 32'd2);
        end
    endtask

    initial begin
        int base;
        bit ok;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ready", {31'd0, sample_ready_o}, 32'd1);
        chk("rst_data", {24'd0, data_o}, 32'h00);
        chk("rst_dvld", {31'd0, data_valid_strobe_o}, 32'd0);
        chk("rst_done", {31'd0, frame_done_strobe_o}, 32'd0);
        chk("rst_ovr", {31'd0, overrun_o}, 32'd0);
        chk("rst_u_outs", {28'd0, sample_ready_u, data_valid_u, frame_done_u, overrun_u}, 32'b1000);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Sample 0x000: latency and first byte
        send(12'h000);
        chk("lat_ready", {31'd0, sample_ready_o}, 32'd0);
        chk("lat_c1_dvld", {31'd0, data_valid_strobe_o}, 32'd0);
        @(posedge clk_i); #1;
        chk("lat_c2_dvld", {31'd0, data_valid_strobe_o}, 32'd1);
        chk("lat_c2_data", {24'd0, data_o}, 32'h38);
        chk("lat_ready_back", {31'd0, sample_ready_o}, 32'd1);
        wait_frame("s000", 16'h3800, 16'h3000);

        send(12'h7FF);
        wait_frame("s7ff", 16'h3FFF, 16'h37FF);
        send(12'h800);
        wait_frame("s800", 16'h3000, 16'h3800);
        send(12'h123);
        wait_frame("s123", 16'h3923, 16'h3123);

        // Three strobes during one frame: A fills, B and C overwrite
        base = ovr_cnt;
        send(12'h456);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (data_valid_strobe_o) begin ok = 1'b1; break; end
            @(posedge clk_i); #1;
        end
        chk("ovr_started", {31'd0, ok}, 32'd1);
        repeat (3) @(posedge clk_i);
        #1;
        send(12'h111);
        repeat (3) @(posedge clk_i);
        #1;
        send(12'h222);
        repeat (3) @(posedge clk_i);
        #1;
        send(12'hABC);
        wait_frame("ovr_x", 16'h3C56, 16'h3456);
        wait_frame("ovr_c", 16'h32BC, 16'h3ABC);
        chk("ovr_count", ovr_cnt - base, 32'd2);
        repeat (100) @(posedge clk_i);
        #1;
        chk("ovr_no_extra", rx_q.size(), 32'd0);
        chk("ovr_ready", {31'd0, sample_ready_o}, 32'd1);

        // Strobe coincident with the IDLE consume refills without overrun
        base = ovr_cnt;
        sample_i = 12'h001;
        sample_valid_strobe_i = 1'b1;
        @(posedge clk_i); #1;
        sample_i = 12'hFFF;
        @(posedge clk_i); #1;
        sample_valid_strobe_i = 1'b0;
        wait_frame("coin_1", 16'h3801, 16'h3001);
        wait_frame("coin_2", 16'h37FF, 16'h3FFF);
        chk("coin_ovr", ovr_cnt - base, 32'd0);

        // Reset while waiting for byte 0 to finish
        send(12'h555);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!tx_ready_i) begin ok = 1'b1; break; end
            @(posedge clk_i); #1;
        end
        chk("mid_busy", {31'd0, ok}, 32'd1);
        repeat (3) @(posedge clk_i);
        #1;
        chk("mid_data_pre", {24'd0, data_o}, 32'h3D);
        base = done_cnt;
        chk_stable = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("mid_rst_data", {24'd0, data_o}, 32'h00);
        chk("mid_rst_ready", {31'd0, sample_ready_o}, 32'd1);
        chk("mid_rst_strobes", {29'd0, data_valid_strobe_o, frame_done_strobe_o, overrun_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (tx_ready_i) begin ok = 1'b1; break; end
            @(posedge clk_i); #1;
        end
        chk("mid_master_idle", {31'd0, ok}, 32'd1);
        repeat (5) @(posedge clk_i);
        #1;
        chk("mid_no_done", done_cnt - base, 32'd0);
        chk("mid_no_strobe", {31'd0, data_valid_strobe_o}, 32'd0);
        rx_q.delete();
        rx_u_q.delete();
        chk_stable = 1'b1;
        send(12'h3A5);
        wait_frame("post_rst", 16'h3BA5, 16'h33A5);

        chk("data_stable", stab_err, 32'd0);
        chk("no_leftover", rx_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_frame_sender.md
DAC_FRAME_SENDER -- requirements
Module: dac_frame_sender

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 12: width of the incoming wave sample.
REQ-002 SHALL have parameter CONFIG_NIBBLE, default 4'b0011: DAC command bits placed in frame[15:12] (ch A, unbuffered, 1x gain, active).
REQ-003 SHALL have parameter SIGNED_INPUT, default 1: 1 = two's-complement sample converted to offset binary; 0 = passed unchanged.
REQ-004 SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-005 Ports SHALL be:
  clk_i  input  1  system clock
  rst_i  input  1  asynchronous active-high reset
  sample_i  input  SAMPLE_WIDTH  wave sample
  sample_valid_strobe_i  input  1  one-cycle strobe, sample_i valid
  sample_ready_o  output  1  pending buffer empty
  data_o  output  8  byte to SPI TX master
  data_valid_strobe_o  output  1  one-cycle strobe to SPI TX master
  tx_ready_i  input  1  SPI TX master idle/ready
  frame_done_strobe_o  output  1  one-cycle pulse, both bytes sent
  overrun_o  output  1  one-cycle pulse, pending sample overwritten

Function
REQ-006 Frame SHALL be 16 bits: {CONFIG_NIBBLE, dac_word[11:0]}; dac_word = sample with MSB inverted when SIGNED_INPUT=1, else sample unchanged.
REQ-007 SAMPLE_WIDTH <12 SHALL be left-aligned (zero LSB padding) into dac_word; >12 SHALL keep the 12 MSBs.
REQ-008 One-entry pending buffer: sample_valid_strobe_i SHALL capture the converted frame and set pending_valid on the same clock edge.
REQ-009 sample_ready_o SHALL equal ~pending_valid.
REQ-010 Strobe while pending_valid=1 and not being consumed this cycle SHALL overwrite pending and pulse overrun_o for one cycle.
REQ-011 Strobe in the same cycle the FSM consumes pending SHALL refill pending; overrun_o SHALL stay 0.
REQ-012 FSM states: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
REQ-013 IDLE: if pending_valid, SHALL move frame into shift register, clear pending_valid, clear byte index, go SEND.
REQ-014 SEND: data_valid_strobe_o=1 for exactly one cycle with data_o = frame[15:8] (index 0) or frame[7:0] (index 1); go WAIT_BUSY.
REQ-015 WAIT_BUSY: remain until tx_ready_i=0, then go WAIT_DONE; minimum dwell 1 cycle.
REQ-016 WAIT_DONE: on tx_ready_i=1, index 0 -> set index 1, go SEND; index 1 -> pulse frame_done_strobe_o, go IDLE.
REQ-017 data_o SHALL remain stable from SEND until leaving WAIT_DONE (the SPI master reads data live during shifting).
REQ-018 Latency: data_valid_strobe_o SHALL assert 2 cycles after sample_valid_strobe_i when FSM is IDLE and pending empty.
REQ-019 data_valid_strobe_o SHALL never assert outside SEND; byte order SHALL be MSB byte first.

Reset
REQ-020 rst_i=1 SHALL asynchronously force: state IDLE, pending_valid 0, byte index 0, data_o 8'h00, data_valid_strobe_o 0, frame_done_strobe_o 0, overrun_o 0; sample_ready_o therefore 1.
REQ-021 Reset mid-frame SHALL abandon the frame; no frame_done_strobe_o for it; after release the next captured sample starts a fresh frame.

Structure
REQ-022 Shared package SHALL hold the FSM state encoding, the 16-bit frame width and the DAC data width (12).
REQ-023 No sub-module; block SHALL be instantiated at top level directly upstream of the SPI TX master, data_o->data_i, data_valid_strobe_o->strobe, tx_ready_o->tx_ready_i.

Verification
REQ-024 Sample 12'h000 (signed) -> bytes 8'h38 then 8'h00, one frame_done_strobe_o.
REQ-025 Sample 12'h7FF -> 8'h3F, 8'hFF; sample 12'h800 -> 8'h30, 8'h00; SIGNED_INPUT=0 with 12'h123 -> 8'h31, 8'h23.
REQ-026 Three strobes during one frame (samples A,B,C) -> overrun_o pulses twice, next frame carries C only.
REQ-027 Strobe coincident with IDLE->SEND consume -> no overrun, both frames sent back-to-back.
REQ-028 Reset asserted in WAIT_DONE of byte 0 -> all outputs at reset values immediately, no frame_done_strobe_o, next sample sent correctly.
REQ-029 Closed loop with SPI TX master (mode 0, CLKS_PER_HALF_BIT=2) -> MOSI shows 16 bits MSB first matching frame, data_o never changes while master is busy.
